// File: rtl/axi4_mid_swap_skid_pkg.sv
// Shared MID AXI4 types: swap-mode encodings, beat payloads and the unit-permutation helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axi4_mid_swap_skid_pkg;

   typedef enum logic [1:0] {
      SWAP_PASS         = 2'b00,
      SWAP_FULL         = 2'b01,
      SWAP_WORD         = 2'b10,
      SWAP_BYTE_IN_WORD = 2'b11
   } swap_mode_t;

   localparam int MID_DATA_W = 512;
   localparam int MID_ID_W   = 1;

   // Canonical MID-width beat payloads (last travels beside the payload).
   typedef struct packed {
      logic [MID_ID_W-1:0]   id;
      logic [1:0]            resp;
      logic [MID_DATA_W-1:0] data;
   } mid_r_beat_t;

   typedef struct packed {
      logic [MID_DATA_W/8-1:0] strb;
      logic [MID_DATA_W-1:0]   data;
   } mid_w_beat_t;

   // Source unit index for output unit i of an n-unit lane under the given mode.
   // A unit is a byte for data and a bit for strobes, so one map serves both.
   function automatic int mid_swap_src(input int i, input int n, input swap_mode_t mode);
      int src;
      src = i;
      case (mode)
         SWAP_FULL:         src = n - 1 - i;
         SWAP_WORD:         src = (n / 4 - 1 - i / 4) * 4 + (i % 4);
         SWAP_BYTE_IN_WORD: src = (i / 4) * 4 + 3 - (i % 4);
         default:           src = i;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/axi4_mid_swap_skid_swap_skid_stage.sv
// Output register + one skid register per channel, with burst tracking, mode latch and beat/burst counters.
// Latency: beat accepted at edge k is presented on out_* from edge k (visible cycle k+1).
// Backpressure: in_rdy is registered !skid_vld; at most two beats held while out_rdy is low.
module swap_skid_stage
   import axi4_mid_swap_skid_pkg::*;
#(
   parameter int PW    = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       swap_mode,
   output swap_mode_t       mode_q,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [PW-1:0]    in_dat,
   input  logic             in_last,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [PW-1:0]    out_dat,
   output logic             out_last,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] beats,
   output logic [CNT_W-1:0] bursts
);

   logic          rdy_q;
   logic          skid_vld;
   logic          skid_nxt;
   logic [PW-1:0] skid_dat;
   logic          skid_last;
   logic          burst_open;
   logic          burst_open_nxt;
   logic          acc;
   logic          fire;

   assign in_rdy = rdy_q;
   assign acc    = in_vld & rdy_q;
   assign fire   = out_vld & out_rdy;

   // Skid occupancy after this edge: a drain always empties it, a stalled accept fills it.
   always_comb begin
      skid_nxt       = skid_vld;
      burst_open_nxt = burst_open;
      if (fire)
         skid_nxt = 1'b0;
      else if (out_vld && acc)
         skid_nxt = 1'b1;
      if (acc)
         burst_open_nxt = !in_last;
   end

   // Output and skid registers; skid always drains into the output before new input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q     <= 1'b0;
         skid_vld  <= 1'b0;
         skid_dat  <= '0;
         skid_last <= 1'b0;
         out_vld   <= 1'b0;
         out_dat   <= '0;
         out_last  <= 1'b0;
      end else begin
         rdy_q    <= !skid_nxt;
         skid_vld <= skid_nxt;
         if (fire) begin
            if (skid_vld) begin
               out_dat  <= skid_dat;
               out_last <= skid_last;
               out_vld  <= 1'b1;
            end else if (acc) begin
               out_dat  <= in_dat;
               out_last <= in_last;
               out_vld  <= 1'b1;
            end else begin
               out_vld  <= 1'b0;
            end
         end else if (!out_vld) begin
            if (acc) begin
               out_dat  <= in_dat;
               out_last <= in_last;
               out_vld  <= 1'b1;
            end
         end else if (acc) begin
            skid_dat  <= in_dat;
            skid_last <= in_last;
         end
      end
   end

   // Burst tracking; the mode is only re-latched when no burst is open after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_open <= 1'b0;
         mode_q     <= SWAP_PASS;
      end else begin
         burst_open <= burst_open_nxt;
         if (!burst_open_nxt)
            mode_q <= swap_mode_t'(swap_mode);
      end
   end

   // Delivered beat and burst counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats  <= '0;
         bursts <= '0;
      end else if (cnt_clear) begin
         beats  <= '0;
         bursts <= '0;
      end else if (fire) begin
         beats <= beats + 1'b1;
         if (out_last)
            bursts <= bursts + 1'b1;
      end
   end

endmodule

// File: rtl/axi4_mid_swap_skid.sv
// Endianness-conversion stage for MID AXI4 R and W channels with per-channel skid buffering and counters.
// Latency: one registered stage; input handshake at edge k presents the beat from edge k.
// Backpressure: full-throughput skid per channel; s_*_ready drops only once two beats are held.
module axi4_mid_swap_skid
   import axi4_mid_swap_skid_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter int ID_W   = 1,
   parameter int CNT_W  = 32
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic [1:0]          r_swap_mode,
   input  logic [1:0]          w_swap_mode,
   input  logic                s_r_valid,
   output logic                s_r_ready,
   input  logic [DATA_W-1:0]   s_r_data,
   input  logic [ID_W-1:0]     s_r_id,
   input  logic [1:0]          s_r_resp,
   input  logic                s_r_last,
   output logic                m_r_valid,
   input  logic                m_r_ready,
   output logic [DATA_W-1:0]   m_r_data,
   output logic [ID_W-1:0]     m_r_id,
   output logic [1:0]          m_r_resp,
   output logic                m_r_last,
   input  logic                s_w_valid,
   output logic                s_w_ready,
   input  logic [DATA_W-1:0]   s_w_data,
   input  logic [DATA_W/8-1:0] s_w_strb,
   input  logic                s_w_last,
   output logic                m_w_valid,
   input  logic                m_w_ready,
   output logic [DATA_W-1:0]   m_w_data,
   output logic [DATA_W/8-1:0] m_w_strb,
   output logic                m_w_last,
   input  logic                cnt_clear,
   output logic [CNT_W-1:0]    r_beats,
   output logic [CNT_W-1:0]    r_bursts,
   output logic [CNT_W-1:0]    w_beats,
   output logic [CNT_W-1:0]    w_bursts
);

   localparam int NB = DATA_W / 8;

   if (DATA_W % 64 != 0) begin : g_bad_width
      $error("axi4_mid_swap_skid: DATA_W must be a multiple of 64");
   end

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic [DATA_W-1:0] data;
   } r_pl_t;

   typedef struct packed {
      logic [NB-1:0]     strb;
      logic [DATA_W-1:0] data;
   } w_pl_t;

   swap_mode_t        r_mode_q;
   swap_mode_t        w_mode_q;
   logic [DATA_W-1:0] r_dat_sw;
   logic [DATA_W-1:0] w_dat_sw;
   logic [NB-1:0]     w_strb_sw;
   r_pl_t             r_in;
   r_pl_t             r_out;
   w_pl_t             w_in;
   w_pl_t             w_out;

   // Each output unit picks one of four fixed sources; the latched mode selects which.
   for (genvar g = 0; g < NB; g++) begin : g_swap
      localparam int FS = mid_swap_src(g, NB, SWAP_FULL);
      localparam int WS = mid_swap_src(g, NB, SWAP_WORD);
      localparam int BS = mid_swap_src(g, NB, SWAP_BYTE_IN_WORD);

      assign r_dat_sw[g*8 +: 8] = (r_mode_q == SWAP_FULL)         ? s_r_data[FS*8 +: 8] :
                                  (r_mode_q == SWAP_WORD)         ? s_r_data[WS*8 +: 8] :
                                  (r_mode_q == SWAP_BYTE_IN_WORD) ? s_r_data[BS*8 +: 8] :
                                                                    s_r_data[g*8 +: 8];
      assign w_dat_sw[g*8 +: 8] = (w_mode_q == SWAP_FULL)         ? s_w_data[FS*8 +: 8] :
                                  (w_mode_q == SWAP_WORD)         ? s_w_data[WS*8 +: 8] :
                                  (w_mode_q == SWAP_BYTE_IN_WORD) ? s_w_data[BS*8 +: 8] :
                                                                    s_w_data[g*8 +: 8];
      assign w_strb_sw[g]       = (w_mode_q == SWAP_FULL)         ? s_w_strb[FS] :
                                  (w_mode_q == SWAP_WORD)         ? s_w_strb[WS] :
                                  (w_mode_q == SWAP_BYTE_IN_WORD) ? s_w_strb[BS] :
                                                                    s_w_strb[g];
   end

   assign r_in = '{id: s_r_id, resp: s_r_resp, data: r_dat_sw};
   assign w_in = '{strb: w_strb_sw, data: w_dat_sw};

   assign m_r_data = r_out.data;
   assign m_r_id   = r_out.id;
   assign m_r_resp = r_out.resp;
   assign m_w_data = w_out.data;
   assign m_w_strb = w_out.strb;

   swap_skid_stage #(
      .PW    ($bits(r_pl_t)),
      .CNT_W (CNT_W)
   ) u_r_stage (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .swap_mode (r_swap_mode),
      .mode_q    (r_mode_q),
      .in_vld    (s_r_valid),
      .in_rdy    (s_r_ready),
      .in_dat    (r_in),
      .in_last   (s_r_last),
      .out_vld   (m_r_valid),
      .out_rdy   (m_r_ready),
      .out_dat   (r_out),
      .out_last  (m_r_last),
      .cnt_clear (cnt_clear),
      .beats     (r_beats),
      .bursts    (r_bursts)
   );

   swap_skid_stage #(
      .PW    ($bits(w_pl_t)),
      .CNT_W (CNT_W)
   ) u_w_stage (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .swap_mode (w_swap_mode),
      .mode_q    (w_mode_q),
      .in_vld    (s_w_valid),
      .in_rdy    (s_w_ready),
      .in_dat    (w_in),
      .in_last   (s_w_last),
      .out_vld   (m_w_valid),
      .out_rdy   (m_w_ready),
      .out_dat   (w_out),
      .out_last  (m_w_last),
      .cnt_clear (cnt_clear),
      .beats     (w_beats),
      .bursts    (w_bursts)
   );

endmodule

// File: tb/tb_axi4_mid_swap_skid.sv
// Self-checking bench for axi4_mid_swap_skid: queue model of both channels plus directed literal checks.
// Latency: n/a.
// Backpressure: exercised by holding m_w_ready / m_r_ready low.
module tb_axi4_mid_swap_skid;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic [1:0]   r_swap_mode, w_swap_mode;
   logic         s_r_valid, s_r_ready;
   logic [511:0] s_r_data;
   logic [0:0]   s_r_id;
   logic [1:0]   s_r_resp;
   logic         s_r_last;
   logic         m_r_valid, m_r_ready;
   logic [511:0] m_r_data;
   logic [0:0]   m_r_id;
   logic [1:0]   m_r_resp;
   logic         m_r_last;
   logic         s_w_valid, s_w_ready;
   logic [511:0] s_w_data;
   logic [63:0]  s_w_strb;
   logic         s_w_last;
   logic         m_w_valid, m_w_ready;
   logic [511:0] m_w_data;
   logic [63:0]  m_w_strb;
   logic         m_w_last;
   logic         cnt_clear;
   logic [31:0]  r_beats, r_bursts, w_beats, w_bursts;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 ap_clk = ~ap_clk;

   axi4_mid_swap_skid dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .r_swap_mode(r_swap_mode), .w_swap_mode(w_swap_mode),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
      .s_r_id(s_r_id), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
      .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
      .s_w_strb(s_w_strb), .s_w_last(s_w_last),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
      .m_w_strb(m_w_strb), .m_w_last(m_w_last),
      .cnt_clear(cnt_clear),
      .r_beats(r_beats), .r_bursts(r_bursts), .w_beats(w_beats), .w_bursts(w_bursts)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference swap on byte arrays; word reverse is built as full reverse then in-word reverse.
   function automatic logic [511:0] swap_d(input logic [511:0] d, input logic [1:0] m);
      logic [7:0] u [64];
      logic [7:0] v [64];
      logic [511:0] r;
      for (int i = 0; i < 64; i++) u[i] = d[8*i +: 8];
      if (m == 2'b01 || m == 2'b10) begin
         for (int i = 0; i < 64; i++) v[i] = u[63-i];
         u = v;
      end
      if (m == 2'b11 || m == 2'b10) begin
         for (int i = 0; i < 64; i++) v[i] = u[i ^ 3];
         u = v;
      end
      for (int i = 0; i < 64; i++) r[8*i +: 8] = u[i];
      return r;
   endfunction

   function automatic logic [63:0] swap_s(input logic [63:0] s, input logic [1:0] m);
      logic [511:0] e, e2;
      logic [63:0]  r;
      e = '0;
      for (int i = 0; i < 64; i++) e[8*i] = s[i];
      e2 = swap_d(e, m);
      for (int i = 0; i < 64; i++) r[i] = e2[8*i];
      return r;
   endfunction

   function automatic logic [511:0] pat(input int base);
      logic [511:0] r;
      for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(base + i);
      return r;
   endfunction

   // ---------------- model and per-cycle compare ----------------
   typedef struct {
      logic [511:0] d;
      logic [63:0]  s;
      logic [0:0]   id;
      logic [1:0]   resp;
      logic         last;
   } beat_t;

   beat_t       rq[$], wq[$];
   beat_t       b;
   logic        r_open, w_open, was_rst;
   logic [1:0]  r_mode, w_mode;
   logic [31:0] mr_beats, mr_bursts, mw_beats, mw_bursts;

   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         rq.delete(); wq.delete();
         r_open = 0; w_open = 0; r_mode = 0; w_mode = 0; was_rst = 1;
         mr_beats = 0; mr_bursts = 0; mw_beats = 0; mw_bursts = 0;
         chk("rst_m_r_valid", 512'(m_r_valid), 512'(0));
         chk("rst_s_r_ready", 512'(s_r_ready), 512'(0));
         chk("rst_m_w_valid", 512'(m_w_valid), 512'(0));
         chk("rst_s_w_ready", 512'(s_w_ready), 512'(0));
      end else begin
         // R channel
         chk("r_valid", 512'(m_r_valid), 512'(rq.size() > 0));
         chk("r_ready", 512'(s_r_ready), 512'(!was_rst && rq.size() < 2));
         if (m_r_valid && rq.size() > 0) begin
            chk("r_data", m_r_data, rq[0].d);
            chk("r_id",   512'(m_r_id), 512'(rq[0].id));
            chk("r_resp", 512'(m_r_resp), 512'(rq[0].resp));
            chk("r_last", 512'(m_r_last), 512'(rq[0].last));
         end
         chk("r_beats",  512'(r_beats),  512'(mr_beats));
         chk("r_bursts", 512'(r_bursts), 512'(mr_bursts));
         if (cnt_clear) begin
            mr_beats = 0; mr_bursts = 0;
         end else if (m_r_valid && m_r_ready) begin
            mr_beats++;
            if (m_r_last) mr_bursts++;
         end
         if (m_r_valid && m_r_ready && rq.size() > 0) void'(rq.pop_front());
         if (s_r_valid && s_r_ready) begin
            b.d = swap_d(s_r_data, r_mode); b.s = '0;
            b.id = s_r_id; b.resp = s_r_resp; b.last = s_r_last;
            rq.push_back(b);
            r_open = !s_r_last;
         end
         if (!r_open) r_mode = r_swap_mode;
         // W channel
         chk("w_valid", 512'(m_w_valid), 512'(wq.size() > 0));
         chk("w_ready", 512'(s_w_ready), 512'(!was_rst && wq.size() < 2));
         if (m_w_valid && wq.size() > 0) begin
            chk("w_data", m_w_data, wq[0].d);
            chk("w_strb", 512'(m_w_strb), 512'(wq[0].s));
            chk("w_last", 512'(m_w_last), 512'(wq[0].last));
         end
         chk("w_beats",  512'(w_beats),  512'(mw_beats));
         chk("w_bursts", 512'(w_bursts), 512'(mw_bursts));
         if (cnt_clear) begin
            mw_beats = 0; mw_bursts = 0;
         end else if (m_w_valid && m_w_ready) begin
            mw_beats++;
            if (m_w_last) mw_bursts++;
         end
         if (m_w_valid && m_w_ready && wq.size() > 0) void'(wq.pop_front());
         if (s_w_valid && s_w_ready) begin
            b.d = swap_d(s_w_data, w_mode); b.s = swap_s(s_w_strb, w_mode);
            b.id = '0; b.resp = '0; b.last = s_w_last;
            wq.push_back(b);
            w_open = !s_w_last;
         end
         if (!w_open) w_mode = w_swap_mode;
         was_rst = 0;
      end
   end

   // ---------------- drivers (called at posedge+1) ----------------
   task automatic r_beat(input logic [511:0] d, input logic [0:0] id, input logic [1:0] resp, input logic l);
      int n;
      s_r_valid = 1; s_r_data = d; s_r_id = id; s_r_resp = resp; s_r_last = l;
      n = 0;
      do begin @(negedge ap_clk); n++; end while (!s_r_ready && n < 200);
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL r_handshake_timeout: got no s_r_ready required within 200 cycles");
      end
      @(posedge ap_clk); #1;
      s_r_valid = 0;
   endtask

   task automatic w_beat(input logic [511:0] d, input logic [63:0] s, input logic l);
      int n;
      s_w_valid = 1; s_w_data = d; s_w_strb = s; s_w_last = l;
      n = 0;
      do begin @(negedge ap_clk); n++; end while (!s_w_ready && n < 200);
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL w_handshake_timeout: got no s_w_ready required within 200 cycles");
      end
      @(posedge ap_clk); #1;
      s_w_valid = 0;
   endtask

   // ---------------- directed sequence ----------------
   logic [511:0] d;

   initial begin
      ap_rst_n = 0; r_swap_mode = 0; w_swap_mode = 0; cnt_clear = 0;
      s_r_valid = 0; s_r_data = '0; s_r_id = '0; s_r_resp = '0; s_r_last = 0;
      s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 0;
      m_r_ready = 1; m_w_ready = 1;

      // reset state
      #12;
      chk("reset_m_r_data", m_r_data, 512'(0));
      chk("reset_m_w_strb", 512'(m_w_strb), 512'(0));
      chk("reset_r_beats", 512'(r_beats), 512'(0));
      chk("reset_w_bursts", 512'(w_bursts), 512'(0));
      repeat (2) @(posedge ap_clk); #1;
      ap_rst_n = 1;
      chk("ready_before_edge", 512'(s_r_ready), 512'(0));
      @(posedge ap_clk); #1;
      chk("s_r_ready_after_edge", 512'(s_r_ready), 512'(1));
      chk("s_w_ready_after_edge", 512'(s_w_ready), 512'(1));

      // R full-beat byte reverse
      r_swap_mode = 2'b01;
      @(posedge ap_clk); #1;
      r_beat(pat(0), 1'b1, 2'b10, 1'b1);
      chk("r01_byte0", 512'(m_r_data[7:0]), 512'(8'h3F));
      chk("r01_byte63", 512'(m_r_data[511:504]), 512'(8'h00));
      chk("r01_id", 512'(m_r_id), 512'(1));
      chk("r01_resp", 512'(m_r_resp), 512'(2'b10));
      chk("r01_last", 512'(m_r_last), 512'(1));

      // W byte reverse within words, strobes follow
      w_swap_mode = 2'b11;
      @(posedge ap_clk); #1;
      d = '0;
      d[127:0] = 128'h0C0D0E0F_08090A0B_04050607_00010203;
      w_beat(d, 64'h000000000000000F, 1'b1);
      chk("w11_word0", 512'(m_w_data[31:0]), 512'(32'h03020100));
      chk("w11_word3", 512'(m_w_data[127:96]), 512'(32'h0F0E0D0C));
      chk("w11_strb", 512'(m_w_strb), 512'(64'h000000000000000F));

      // mode change mid-burst is ignored until the burst closes
      r_swap_mode = 2'b00;
      @(posedge ap_clk); #1;
      r_beat(pat(8'h10), 1'b0, 2'b00, 1'b0);
      r_swap_mode = 2'b10;
      for (int k = 1; k < 4; k++) begin
         r_beat(pat(8'h10 + 16*k), 1'b0, 2'b00, k == 3);
         d = pat(8'h10 + 16*k);
         chk("r_midburst_pass", m_r_data, d);
      end
      d = pat(8'h50);
      r_beat(d, 1'b0, 2'b01, 1'b1);
      chk("r10_word0", 512'(m_r_data[31:0]), 512'(d[511:480]));
      chk("r10_word15", 512'(m_r_data[511:480]), 512'(d[31:0]));

      // W backpressure with an 8-beat back-to-back burst
      cnt_clear = 1;
      @(posedge ap_clk); #1;
      cnt_clear = 0;
      m_w_ready = 0;
      fork
         begin
            for (int k = 0; k < 8; k++) w_beat(pat(16*k + 3), '1, k == 7);
         end
         begin
            repeat (3) @(negedge ap_clk);
            chk("w_ready_low_two_held", 512'(s_w_ready), 512'(0));
            chk("w_valid_held", 512'(m_w_valid), 512'(1));
            repeat (3) @(posedge ap_clk); #1;
            m_w_ready = 1;
         end
      join
      repeat (4) @(posedge ap_clk); #1;
      chk("w_beats_8", 512'(w_beats), 512'(8));
      chk("w_bursts_1", 512'(w_bursts), 512'(1));

      // clear coincident with an R output handshake
      r_beat(pat(8'h60), 1'b1, 2'b00, 1'b1);
      cnt_clear = 1;
      @(posedge ap_clk); #1;
      cnt_clear = 0;
      chk("clear_wins_r_beats", 512'(r_beats), 512'(0));
      chk("clear_wins_r_bursts", 512'(r_bursts), 512'(0));

      // asynchronous reset mid-burst with beats held
      m_r_ready = 0;
      r_beat(pat(8'h80), 1'b0, 2'b00, 1'b0);
      r_beat(pat(8'h90), 1'b0, 2'b00, 1'b0);
      chk("mode_q_before_reset", 512'(dut.u_r_stage.mode_q), 512'(2'b10));
      ap_rst_n = 0;
      #1;
      chk("async_rst_m_r_valid", 512'(m_r_valid), 512'(0));
      chk("async_rst_mode_q", 512'(dut.u_r_stage.mode_q), 512'(0));
      chk("async_rst_m_r_data", m_r_data, 512'(0));
      m_r_ready = 1;
      repeat (2) @(posedge ap_clk); #1;
      ap_rst_n = 1;
      @(posedge ap_clk); #1;
      r_swap_mode = 2'b01;
      @(posedge ap_clk); #1;
      r_beat(pat(5), 1'b0, 2'b00, 1'b1);
      chk("post_rst_r01_byte0", 512'(m_r_data[7:0]), 512'(8'h44));
      chk("post_rst_last", 512'(m_r_last), 512'(1));

      repeat (3) @(posedge ap_clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi4_mid_swap_skid.md
# axi4_mid_swap_skid

Registered endianness-conversion stage for the 512-bit MID AXI4 data channels, inserted between the memory-side AXI4 master and the engine datapath. It reorders R-channel read data and W-channel write data/strobes at a runtime-selectable granularity, registers both paths with full-throughput skid buffers, and counts delivered beats and bursts. It generalises the existing whole-line byte swap:

- Data width is parametrised.
- Two channels are handled.
- The swap mode changes only on burst boundaries.

## Interface
Parameters:
- DATA_W, 512, beat width in bits; must be a multiple of 64 (elaboration error otherwise).
- ID_W, 1, AXI ID width carried on R.
- CNT_W, 32, width of the beat and burst counters.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- r_swap_mode  in  2  R-channel mode: 00 pass, 01 full-beat byte reverse, 10 32-bit-word reverse, 11 byte reverse within each 32-bit word.
- w_swap_mode  in  2  W-channel mode, same encoding.
- s_r_valid / s_r_ready  in / out  1  R beat from memory.
- s_r_data  in  DATA_W  read data from memory.
- s_r_id  in  ID_W  read ID.
- s_r_resp  in  2  read response.
- s_r_last  in  1  last beat of read burst.
- m_r_valid / m_r_ready  out / in  1  R beat to engine.
- m_r_data  out  DATA_W  read data to engine.
- m_r_id  out  ID_W  read ID.
- m_r_resp  out  2  read response.
- m_r_last  out  1  last beat of read burst.
- s_w_valid / s_w_ready  in / out  1  W beat from engine.
- s_w_data  in  DATA_W  write data from engine.
- s_w_strb  in  DATA_W/8  write strobes.
- s_w_last  in  1  last beat of write burst.
- m_w_valid / m_w_ready  out / in  1  W beat to memory.
- m_w_data  out  DATA_W  write data to memory.
- m_w_strb  out  DATA_W/8  write strobes.
- m_w_last  out  1  last beat of write burst.
- cnt_clear  in  1  synchronous clear of all counters.
- r_beats, r_bursts, w_beats, w_bursts  out  CNT_W  counts of output handshakes and of output handshakes with last.

## Operation
- R and W channels are independent and identical in mechanism.
- Transform is applied at input acceptance using the channel's latched mode_q.
  - Mode 01: out byte i = in byte (N-1-i), where N = DATA_W/8.
  - Mode 10: out word i = in word (W-1-i), where W = DATA_W/32; bytes within each word keep their order.
  - Mode 11: out byte 4k+j = in byte 4k+(3-j).
- W strobes are permuted with the identical byte mapping.
- id, resp and last pass through unmodified.
- Per-channel burst_open flag:
  - Set by an accepted non-last beat.
  - Cleared by an accepted last beat.
- mode_q loads the swap_mode input at every edge where burst_open is 0 after that edge. A beat accepted at that same edge uses the old mode_q. Mode inputs are therefore ignored mid-burst.
- Skid stage per channel: output register plus one skid register.
  - s_*_ready = !skid_valid (registered).
  - When the output stalls and a beat is accepted, the beat goes to skid.
  - When the output drains, skid moves to the output register first.
  - Ordering is strictly preserved.
- Counters increment on m_*_valid & m_*_ready; burst counters increment only when last is also high. Both wrap at 2^CNT_W.
- cnt_clear has priority over a simultaneous increment; the counter reads 0 the next cycle.

## Timing
- Reset values:
  - All m_*_valid = 0, s_*_ready = 0.
  - All data/strb/id/resp/last outputs = 0.
  - Counters = 0, burst_open = 0, mode_q = 00.
- s_*_ready rises on the first ap_clk edge after ap_rst_n deasserts.
- Latency: input handshake at edge k gives m_*_valid at edge k (registered); the beat is visible in cycle k+1.
- Throughput: 1 beat/cycle sustained when the downstream ready is held high.
- When the downstream ready is low:
  - At most 2 beats are held.
  - s_*_ready drops the cycle after the skid register fills.
  - s_*_ready returns the cycle after the skid register empties.
- m_*_valid is held with stable payload until its handshake; it is never withdrawn.
- Reset asserted mid-burst discards held beats, clears burst_open and returns mode_q to 00 immediately (asynchronous).

## Structure
- Shared package, MID AXI4 package:
  - Swap-mode typedef and its four encodings.
  - Generalised swap function, parametrised by width and mode, used for both data and strobe permutation.
  - R and W beat payload structs.
- One sub-module, swap_skid_stage, parametrised by payload width. It holds the output and skid registers, the burst_open flag, mode_q and the two counters. It is instantiated twice, once for R and once for W.

## Test plan
- Reset → all outputs 0; s_r_ready and s_w_ready are 1 one edge after ap_rst_n rises.
- r_swap_mode=01, single beat with byte i = i (0x00..0x3F) → m_r_data byte 0 = 0x3F, byte 63 = 0x00; rid, rresp and rlast unchanged.
- W mode=11, data 0x...0C0D0E0F_08090A0B_04050607_00010203 with strb bit i = (i<4) → word 0 bytes = 03,02,01,00; strb unchanged (0x…000F).
- 4-beat R burst with mode switched 00→10 after beat 1 → all 4 beats pass unswapped; the next burst is word-reversed.
- m_w_ready low for 5 cycles during back-to-back input → s_w_ready low after 2 beats are held; no loss, no reorder; w_beats = 8 after an 8-beat burst drains.
- cnt_clear asserted in the same cycle as an output handshake → r_beats = 0 the next cycle; ap_rst_n pulsed mid-burst → m_r_valid = 0 and mode_q = 00 immediately.
